dokmean_udiv_seq: RTL and testbench
===================================

Name: doKmean_udiv_seq

Overview:
- Sequential unsigned restoring divider; the inverse of the centroid-update multiplier path.
- Recovers a narrow quotient and a remainder from a wide product/sum and a divisor, e.g. centroid = coordinate_sum / member_count.
- Sits after the accumulation stage in the doKmean datapath.
- Uses valid/ready handshakes on input and output, one division in flight, fixed latency.

Parameters:
- DIVIDEND_WIDTH, 17, width of dividend; equals number of iteration cycles.
- DIVISOR_WIDTH, 10, width of divisor and remainder.
- QUOTIENT_WIDTH, 7, width of the quotient output port; must be <= DIVIDEND_WIDTH.

Ports:
- ap_clk  in  1  clock; all state changes on rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept an operand pair.
- dividend  in  DIVIDEND_WIDTH  unsigned dividend.
- divisor  in  DIVISOR_WIDTH  unsigned divisor.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- quotient  out  QUOTIENT_WIDTH  low QUOTIENT_WIDTH bits of the full quotient.
- remainder  out  DIVISOR_WIDTH  dividend mod divisor.
- overflow  out  1  full quotient does not fit in QUOTIENT_WIDTH bits.
- div_by_zero  out  1  divisor was 0.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - state=IDLE, iteration counter=0.
  - out_valid=0; quotient, remainder, overflow and div_by_zero all 0.
  - in_ready=1 while in reset and after release.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1, capture dividend and divisor, clear the partial remainder (DIVISOR_WIDTH+1 bits), load counter=DIVIDEND_WIDTH, go to CALC.
  - CALC: in_ready=0. Each edge performs one restoring step, MSB first:
    - t = {partial_rem, next dividend bit}.
    - If t >= divisor: partial_rem = t - divisor and the quotient bit is 1.
    - Else: partial_rem = t and the quotient bit is 0.
    - Decrement the counter. On the edge where the counter reaches 0, register the outputs and go to DONE.
  - DONE: out_valid=1, in_ready=0, outputs stable. On an edge with out_ready=1, go to IDLE with out_valid=0.
- Latency: out_valid rises exactly DIVIDEND_WIDTH cycles after the accepting edge (17 with defaults).
- Throughput: the next operand is accepted no earlier than the cycle after the result handshake; a new division is never accepted in the same cycle a result is consumed. One division per DIVIDEND_WIDTH+2 cycles minimum.
- Width rules:
  - The full quotient is DIVIDEND_WIDTH bits.
  - quotient port = full_q[QUOTIENT_WIDTH-1:0].
  - overflow = OR of full_q[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH].
  - remainder is always < divisor, except in the divide-by-zero case.
- Divide by zero:
  - Detected at capture; the same latency and state sequence still apply.
  - Results: div_by_zero=1, quotient=all ones, remainder=0, overflow=0.
- Dividend 0 with a nonzero divisor: quotient=0, remainder=0, flags 0.
- in_valid while busy (CALC/DONE): ignored, no capture. The operand source must hold its data until in_ready.
- out_ready while not in DONE: ignored.
- Reset mid-operation (CALC or DONE): the in-flight division is discarded. out_valid drops to 0 immediately (asynchronous). After release, state is IDLE and in_ready=1.
- Output registers change only on the CALC to DONE edge and on reset.

Test Plan:
- dividend=1000, divisor=10, out_ready=1 -> out_valid exactly 17 cycles after accept; quotient=100, remainder=0, overflow=0, div_by_zero=0.
- dividend=129921 (127*1023), divisor=1023 -> quotient=127, remainder=0, overflow=0. Then dividend=131071, divisor=1023 -> full quotient 128, so quotient=0, remainder=127, overflow=1.
- dividend=500, divisor=0 -> after 17 cycles: div_by_zero=1, quotient=7'h7F, remainder=0, overflow=0.
- Backpressure: result ready with out_ready=0 for 5 cycles -> out_valid held high, outputs unchanged, in_ready=0. A second in_valid pulse during this time is not captured. With out_ready=1, in_ready=1 from the next cycle.
- Back-to-back: in_valid held high with 3 operand pairs (77/7, 1023/1023, 0/5), out_ready=1 -> results (11,0), (1,0), (0,0) in order, each 17 cycles after its accept, with accepts spaced DIVIDEND_WIDTH+2 cycles apart.
- Reset: assert ap_rst_n low 8 cycles into CALC -> out_valid=0 and all outputs 0 immediately; after release in_ready=1. A new division 200/3 yields quotient=66, remainder=2.

Source files
------------

// File: rtl/dokmean_udiv_seq.sv
// doKmean sequential unsigned restoring divider.
// Narrows an accumulated sum by a member count, one quotient bit per cycle.
module dokmean_udiv_seq #(
  parameter int DIVIDEND_WIDTH = 17,
  parameter int DIVISOR_WIDTH  = 10,
  parameter int QUOTIENT_WIDTH = 7
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      overflow,
  output logic                      div_by_zero
);

  localparam int NW = DIVIDEND_WIDTH;
  localparam int DW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [NW-1:0] dvd_q;
  logic [DW-1:0] dvs_q;
  logic          zero_q;
  logic [DW-1:0] prem_q;
  logic [DW-1:0] prem_d;
  logic [NW-1:0] qf_q;
  logic [NW-1:0] qf_d;

  logic [DW:0]   trial;
  logic [DW-1:0] diff;
  logic          ge;

  logic [QW-1:0] quo_q;
  logic [DW-1:0] rem_q;
  logic          ovf_q;
  logic          dbz_q;
  logic          vld_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The running remainder stays below the divisor, so DW bits hold it and
  // the wrap-around subtract on the low bits is exact.
  always_comb begin
    trial  = {prem_q, dvd_q[NW-1]};
    ge     = trial >= {1'b0, dvs_q};
    diff   = trial[DW-1:0] - dvs_q;
    prem_d = ge ? diff : trial[DW-1:0];
    qf_d   = (qf_q << 1) | NW'(ge);
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      prem_q  <= '0;
      qf_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            zero_q  <= (divisor == '0);
            prem_q  <= '0;
            qf_q    <= '0;
            cnt_q   <= CW'(NW);
            state_q <= CALC;
          end
        end
        CALC: begin
          dvd_q  <= dvd_q << 1;
          prem_q <= prem_d;
          qf_q   <= qf_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (zero_q) begin
              quo_q <= '1;
              rem_q <= '0;
              ovf_q <= 1'b0;
              dbz_q <= 1'b1;
            end else begin
              quo_q <= qf_d[QW-1:0];
              rem_q <= prem_d;
              ovf_q <= |(qf_d >> QW);
              dbz_q <= 1'b0;
            end
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = vld_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_dokmean_udiv_seq.sv
// Bench for dokmean_udiv_seq.
// Scoreboard of reference quotients, one task per scenario.
module tb_dokmean_udiv_seq;

  localparam int NW = 17;
  localparam int DW = 10;
  localparam int QW = 7;
  localparam int LAT = NW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          overflow;
  logic          div_by_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [QW-1:0] q;
    logic [DW-1:0] r;
    logic          ovf;
    logic          dbz;
    int            acc;
  } exp_t;

  exp_t sb[$];

  dokmean_udiv_seq #(
    .DIVIDEND_WIDTH(NW),
    .DIVISOR_WIDTH (DW),
    .QUOTIENT_WIDTH(QW)
  ) dut (
    .ap_clk     (clk),
    .ap_rst_n   (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [NW-1:0] a,
                                 input logic [DW-1:0] b);
    exp_t e;
    logic [NW-1:0] full;
    logic [NW-1:0] md;
    e.acc = 0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = '0;
      e.ovf = 1'b0;
      e.dbz = 1'b1;
    end else begin
      full  = a / {7'd0, b};
      md    = a % {7'd0, b};
      e.q   = full[QW-1:0];
      e.r   = md[DW-1:0];
      e.ovf = |full[NW-1:QW];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Present operands from a negedge and wait for the accepting posedge.
  task automatic send(input logic [NW-1:0] a, input logic [DW-1:0] b,
                      input bit hold, output bit ok, output int acc);
    ok = 1'b0;
    acc = 0;
    dividend = a;
    divisor = b;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        acc = cyc + 1;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Send, record expectation, wait for the result, pop the expectation.
  task automatic run_one(input logic [NW-1:0] a, input logic [DW-1:0] b,
                         output bit ok, output exp_t e, output int lat);
    bit ok1;
    bit ok2;
    int acc;
    int at;
    exp_t m;
    send(a, b, 1'b0, ok1, acc);
    m = model(a, b);
    m.acc = acc;
    sb.push_back(m);
    wait_out(ok2, at);
    e = sb.pop_front();
    lat = at - e.acc;
    ok = ok1 && ok2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    #3;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    total++;
    if ({quotient, remainder, overflow, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_out got q=%0d r=%0d ovf=%b dbz=%b want 0",
               quotient, remainder, overflow, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    bit ok;
    int acc;
    int at;
    exp_t e;
    out_ready = 1'b1;
    send(17'd1000, 10'd10, 1'b0, ok, acc);
    e = model(17'd1000, 10'd10);
    e.acc = acc;
    sb.push_back(e);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy got in_ready=%b want 0", in_ready);
    end
    wait_out(ok, at);
    e = sb.pop_front();
    total++;
    if (!ok || at - e.acc != LAT) begin
      bad++;
      $display("FAIL basic_latency got %0d want %0d (ok=%b)",
               at - e.acc, LAT, ok);
    end
    total++;
    if (quotient !== 7'd100 || remainder !== 10'd0 ||
        overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_result got q=%0d r=%0d ovf=%b dbz=%b want 100 0 0 0",
               quotient, remainder, overflow, div_by_zero);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_handshake got out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_width;
    bit ok;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    run_one(17'd129921, 10'd1023, ok, e, lat);
    total++;
    if (!ok || lat != LAT || quotient !== 7'd127 || remainder !== 10'd0 ||
        overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL width_fit got q=%0d r=%0d ovf=%b lat=%0d want 127 0 0 %0d",
               quotient, remainder, overflow, lat, LAT);
    end
    @(negedge clk);
    run_one(17'd131071, 10'd1023, ok, e, lat);
    total++;
    if (!ok || {quotient, remainder, overflow, div_by_zero} !==
        {e.q, e.r, e.ovf, e.dbz} || overflow !== 1'b1) begin
      bad++;
      $display("FAIL width_ovf got q=%0d r=%0d ovf=%b want %0d %0d %b",
               quotient, remainder, overflow, e.q, e.r, e.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    bit ok;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    run_one(17'd500, 10'd0, ok, e, lat);
    total++;
    if (!ok || lat != LAT) begin
      bad++;
      $display("FAIL dbz_latency got %0d want %0d (ok=%b)", lat, LAT, ok);
    end
    total++;
    if (quotient !== 7'h7F || remainder !== 10'd0 ||
        overflow !== 1'b0 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dbz_result got q=%h r=%0d ovf=%b dbz=%b want 7f 0 0 1",
               quotient, remainder, overflow, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [NW-1:0] av[3];
    logic [DW-1:0] bv[3];
    bit ok;
    int acc;
    int prev;
    int at;
    exp_t e;
    av[0] = 17'd77;   bv[0] = 10'd7;
    av[1] = 17'd1023; bv[1] = 10'd1023;
    av[2] = 17'd0;    bv[2] = 10'd5;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      send(av[i], bv[i], 1'b1, ok, acc);
      e = model(av[i], bv[i]);
      e.acc = acc;
      sb.push_back(e);
      if (i > 0) begin
        total++;
        if (!ok || acc - prev != NW + 2) begin
          bad++;
          $display("FAIL b2b_spacing[%0d] got %0d want %0d", i,
                   acc - prev, NW + 2);
        end
      end
      prev = acc;
      if (i == 2) in_valid = 1'b0;
      wait_out(ok, at);
      e = sb.pop_front();
      total++;
      if (!ok || at - e.acc != LAT ||
          {quotient, remainder, overflow, div_by_zero} !==
          {e.q, e.r, e.ovf, e.dbz}) begin
        bad++;
        $display("FAIL b2b_result[%0d] got q=%0d r=%0d lat=%0d want %0d %0d %0d",
                 i, quotient, remainder, at - e.acc, e.q, e.r, LAT);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok;
    bit seen;
    int lat;
    exp_t e;
    out_ready = 1'b0;
    run_one(17'd300, 10'd7, ok, e, lat);
    total++;
    if (!ok || quotient !== 7'd42 || remainder !== 10'd6) begin
      bad++;
      $display("FAIL bp_result got q=%0d r=%0d want 42 6", quotient, remainder);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        dividend = 17'd999;
        divisor = 10'd3;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {quotient, remainder, overflow, div_by_zero} !==
          {e.q, e.r, e.ovf, e.dbz}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b rdy=%b q=%0d r=%0d want 1 0 %0d %0d",
                 k, out_valid, in_ready, quotient, remainder, e.q, e.r);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_capture got busy=%b want 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int acc;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    send(17'd1234, 10'd5, 1'b0, ok, acc);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {quotient, remainder, overflow, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL rst_calc got v=%b rdy=%b q=%0d r=%0d want 0 1 0 0",
               out_valid, in_ready, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_calc_release got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    out_ready = 1'b0;
    run_one(17'd200, 10'd3, ok, e, lat);
    total++;
    if (!ok || lat != LAT || quotient !== 7'd66 || remainder !== 10'd2) begin
      bad++;
      $display("FAIL rst_after got q=%0d r=%0d lat=%0d want 66 2 %0d",
               quotient, remainder, lat, LAT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      bad++;
      $display("FAIL rst_done got v=%b q=%0d r=%0d want 0 0 0",
               out_valid, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    run_one(17'd5, 10'd2, ok, e, lat);
    total++;
    if (!ok || quotient !== 7'd2 || remainder !== 10'd1) begin
      bad++;
      $display("FAIL rst_done_after got q=%0d r=%0d want 2 1",
               quotient, remainder);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_width();
    test_div_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
